rv32_mem: RTL and testbench
===========================

// Module: rv32_mem
// PURPOSE
//  Memory-access stage; consumes execute-stage outputs (mem enables, rd, ALU result as address, rs2 store data).
//  Drives a single-port data bus with a ready handshake, formats store lanes, aligns/extends load data.
//  Presents rd/rd_writeback/rd_value to writeback; stalls upstream while a bus access is outstanding.
// PARAMETERS
//  WAIT_LIMIT  255  max BUS-state cycles before the access is abandoned as a bus error; 0 = no limit
// PORTS
//  clk                   in   1   clock, all state on rising edge
//  reset_n               in   1   asynchronous, active-low reset
//  mem_read_en_in        in   1   load request
//  mem_write_en_in       in   1   store request
//  mem_width_in          in   2   0=byte 1=half 2=word (3 treated as word)
//  mem_zero_extend_in    in   1   load: 1=zero-extend, 0=sign-extend
//  rd_in                 in   5   destination register
//  rd_writeback_in       in   1   instruction writes rd
//  result_in             in   32  ALU result: address for mem ops, rd value otherwise
//  rs2_value_in          in   32  store data
//  stall_out             out  1   upstream must hold inputs stable; combinational (state!=IDLE)
//  data_address_out      out  32  word-aligned address {addr[31:2],2'b00}
//  data_read_out         out  1   bus read strobe
//  data_write_out        out  1   bus write strobe
//  data_write_mask_out   out  4   byte lane enables
//  data_write_value_out  out  32  lane-replicated store data
//  data_read_value_in    in   32  read data, valid with data_ready_in
//  data_ready_in         in   1   access complete this cycle
//  bus_error_out         out  1   one-cycle pulse: access abandoned after WAIT_LIMIT cycles
//  rd_out                out  5   registered destination
//  rd_writeback_out      out  1   registered writeback enable; forced 0 when rd==0
//  rd_value_out          out  32  registered result/load value
// BEHAVIOUR
//  Reset: every output 0, state IDLE, wait counter 0; reset mid-access drops strobes immediately, no completion.
//  IDLE, no mem op: next edge rd_out/rd_writeback_out/rd_value_out <= rd_in/rd_writeback_in/result_in (1 cycle).
//  IDLE, mem op: next edge latch request, assert strobe + address/mask/data, state->BUS, rd_writeback_out<=0.
//  Read and write both set: treated as store; read ignored.
//  BUS: bus outputs held constant; inputs ignored; counter increments each cycle without data_ready_in.
//  BUS & data_ready_in: next edge strobes 0, state->IDLE; load: rd_value_out<=aligned value,
//   rd_writeback_out<=latched rd_writeback&(rd!=0); store: rd_writeback_out<=0. Min load latency 2 cycles.
//  Timeout (WAIT_LIMIT!=0, counter==WAIT_LIMIT-1, no ready): strobes 0, state->IDLE, bus_error_out pulse, no writeback.
//  Store format: byte mask 4'b0001<<addr[1:0], data {4{rs2[7:0]}}; half mask 4'b0011<<{addr[1],1'b0},
//   data {2{rs2[15:0]}}; word mask 4'b1111, data rs2.
//  Load align: byte lane addr[1:0], half lane addr[1]; extend per mem_zero_extend_in; word passes through.
// CONFIGURATION
//  RV32_MISALIGN_TRAP_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 issues no bus cycle;
//   stays IDLE, trap_out (extra 1-bit output) pulses one cycle, rd_writeback_out<=0.
//  Undefined: no trap_out port; offending low address bits silently ignored as above.
// STRUCTURE
//  rv32_mem_pkg: mem_width_t enum (BYTE/HALF/WORD), state_t enum (IDLE/BUS), lane-mask constants.
//  Sub-module rv32_mem_align: combinational load extraction + sign/zero extension.
// TESTING
//  Non-mem op rd=5, result=0x1234 -> next cycle rd_out=5, rd_writeback_out=1, rd_value_out=0x1234, stall 0.
//  Load byte addr=0x103 signed, ready 3 cycles later, read=0x80FFFFFF -> addr 0x100, rd_value=0xFFFFFF80.
//  Store half addr=0x202 rs2=0xAAAABEEF -> mask 4'b1100, data 0xBEEFBEEF, stall held until ready.
//  WAIT_LIMIT=4, ready never -> strobe low after 4 BUS cycles, bus_error_out pulse, no writeback.
//  reset_n low during BUS -> strobes, stall_out, outputs 0 same cycle; next op serviced normally.
//  With RV32_MISALIGN_TRAP_EN, word load addr=0x101 -> no strobe, trap_out pulse, rd_writeback_out 0.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg
//   Shared types and constants for the RV32 memory-access stage:
//   access width encoding, stage state encoding and store lane masks.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/rv32_mem_align.sv
// rv32_mem_align
//   Combinational load formatting: picks the addressed byte/half lane out of
//   the 32-bit bus word and sign- or zero-extends it. Word loads (and the
//   unused width code 3) pass the bus word through unchanged.
// Ports:
//   rdata  in  32  raw bus read data
//   width  in  2   access width (BYTE/HALF/WORD, 3 treated as WORD)
//   lane   in  2   low address bits of the access
//   zext   in  1   1 = zero-extend, 0 = sign-extend
//   value  out 32  aligned, extended load value
module rv32_mem_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  width,
    input  logic [1:0]  lane,
    input  logic        zext,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        value    = rdata;
        if (width == BYTE) begin
            value = {{24{~zext & byte_sel[7]}}, byte_sel};
        end else if (width == HALF) begin
            value = {{16{~zext & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/rv32_mem.sv
// rv32_mem
//   RV32 memory-access stage. Non-memory instructions flow to writeback in one
//   cycle. Loads/stores are issued on a single-port data bus and held until
//   data_ready_in (or until WAIT_LIMIT BUS cycles elapse, raising a bus error);
//   upstream is stalled while an access is outstanding.
//   Optional build macro RV32_MISALIGN_TRAP_EN: misaligned half/word accesses
//   are not issued and pulse trap_out instead.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   mem_*_in, rd_*_in            request from execute (result_in = address)
//   rs2_value_in                 store data
//   stall_out                    access outstanding, hold inputs
//   data_*_out / data_*_in       data bus (word address, strobes, mask, data, ready)
//   bus_error_out                one-cycle pulse on abandoned access
//   rd_out, rd_writeback_out,
//   rd_value_out                 registered writeback interface
//   trap_out                     misalignment pulse (only with RV32_MISALIGN_TRAP_EN)
module rv32_mem
    import rv32_mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_writeback_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        bus_error_out,
    output logic [4:0]  rd_out,
    output logic        rd_writeback_out,
    output logic [31:0] rd_value_out
`ifdef RV32_MISALIGN_TRAP_EN
    ,
    output logic        trap_out
`endif
);

    state_t      state_q, state_d;
    logic [31:0] wait_cnt;
    logic [4:0]  req_rd;
    logic        req_wb, req_load, req_zext;
    logic [1:0]  req_width, req_lane;
    logic        is_mem, issue, complete, timeout;
    logic [3:0]  st_mask;
    logic [31:0] st_data, ld_value;
`ifdef RV32_MISALIGN_TRAP_EN
    logic        misaligned, trap;
`endif

    assign is_mem    = mem_read_en_in | mem_write_en_in;
    assign stall_out = (state_q != IDLE);

    // Store lane formatting: data is replicated so every enabled lane sees it.
    always_comb begin
        st_mask = MASK_WORD;
        st_data = rs2_value_in;
        if (mem_width_in == BYTE) begin
            st_mask = MASK_BYTE << result_in[1:0];
            st_data = {4{rs2_value_in[7:0]}};
        end else if (mem_width_in == HALF) begin
            st_mask = MASK_HALF << {result_in[1], 1'b0};
            st_data = {2{rs2_value_in[15:0]}};
        end
    end

`ifdef RV32_MISALIGN_TRAP_EN
    assign misaligned = ((mem_width_in == HALF) && result_in[0]) ||
                        ((mem_width_in != BYTE) && (mem_width_in != HALF) &&
                         (result_in[1:0] != 2'b00));
`endif

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
`ifdef RV32_MISALIGN_TRAP_EN
        trap     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (is_mem) begin
`ifdef RV32_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        trap = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = BUS;
                    end
`else
                    issue   = 1'b1;
                    state_d = BUS;
`endif
                end
            end
            BUS: begin
                if (data_ready_in) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if ((WAIT_LIMIT != 0) && (wait_cnt == 32'(WAIT_LIMIT - 1))) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    rv32_mem_align u_align (
        .rdata (data_read_value_in),
        .width (req_width),
        .lane  (req_lane),
        .zext  (req_zext),
        .value (ld_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt             <= '0;
            req_rd               <= '0;
            req_wb               <= 1'b0;
            req_load             <= 1'b0;
            req_zext             <= 1'b0;
            req_width            <= '0;
            req_lane             <= '0;
            data_address_out     <= '0;
            data_read_out        <= 1'b0;
            data_write_out       <= 1'b0;
            data_write_mask_out  <= '0;
            data_write_value_out <= '0;
            bus_error_out        <= 1'b0;
            rd_out               <= '0;
            rd_writeback_out     <= 1'b0;
            rd_value_out         <= '0;
`ifdef RV32_MISALIGN_TRAP_EN
            trap_out             <= 1'b0;
`endif
        end else begin
            bus_error_out <= 1'b0;
`ifdef RV32_MISALIGN_TRAP_EN
            trap_out      <= 1'b0;
`endif
            if (state_q == BUS && !data_ready_in) begin
                wait_cnt <= wait_cnt + 32'd1;
            end

            if (issue) begin
                // A request with both enables set is a store.
                wait_cnt             <= '0;
                req_rd               <= rd_in;
                req_wb               <= rd_writeback_in;
                req_load             <= ~mem_write_en_in;
                req_zext             <= mem_zero_extend_in;
                req_width            <= mem_width_in;
                req_lane             <= result_in[1:0];
                data_address_out     <= {result_in[31:2], 2'b00};
                data_read_out        <= ~mem_write_en_in;
                data_write_out       <= mem_write_en_in;
                data_write_mask_out  <= mem_write_en_in ? st_mask : 4'b0000;
                data_write_value_out <= mem_write_en_in ? st_data : 32'd0;
                rd_out               <= rd_in;
                rd_writeback_out     <= 1'b0;
            end else if (state_q == IDLE) begin
`ifdef RV32_MISALIGN_TRAP_EN
                if (trap) begin
                    trap_out         <= 1'b1;
                    rd_out           <= rd_in;
                    rd_writeback_out <= 1'b0;
                end else
`endif
                begin
                    rd_out           <= rd_in;
                    rd_writeback_out <= rd_writeback_in & (rd_in != 5'd0);
                    rd_value_out     <= result_in;
                end
            end else if (complete || timeout) begin
                data_read_out    <= 1'b0;
                data_write_out   <= 1'b0;
                rd_writeback_out <= 1'b0;
                if (timeout) begin
                    bus_error_out <= 1'b1;
                end else if (req_load) begin
                    rd_value_out     <= ld_value;
                    rd_writeback_out <= req_wb & (req_rd != 5'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_mem.sv
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read_en_in, mem_write_en_in, mem_zero_extend_in;
    logic [1:0]  mem_width_in;
    logic [4:0]  rd_in;
    logic        rd_writeback_in;
    logic [31:0] result_in, rs2_value_in;
    logic        stall_out;
    logic [31:0] data_address_out;
    logic        data_read_out, data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;
    logic        bus_error_out;
    logic [4:0]  rd_out;
    logic        rd_writeback_out;
    logic [31:0] rd_value_out;
`ifdef RV32_MISALIGN_TRAP_EN
    logic        trap_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_mem #(.WAIT_LIMIT(4)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .mem_read_en_in       (mem_read_en_in),
        .mem_write_en_in      (mem_write_en_in),
        .mem_width_in         (mem_width_in),
        .mem_zero_extend_in   (mem_zero_extend_in),
        .rd_in                (rd_in),
        .rd_writeback_in      (rd_writeback_in),
        .result_in            (result_in),
        .rs2_value_in         (rs2_value_in),
        .stall_out            (stall_out),
        .data_address_out     (data_address_out),
        .data_read_out        (data_read_out),
        .data_write_out       (data_write_out),
        .data_write_mask_out  (data_write_mask_out),
        .data_write_value_out (data_write_value_out),
        .data_read_value_in   (data_read_value_in),
        .data_ready_in        (data_ready_in),
        .bus_error_out        (bus_error_out),
        .rd_out               (rd_out),
        .rd_writeback_out     (rd_writeback_out),
        .rd_value_out         (rd_value_out)
`ifdef RV32_MISALIGN_TRAP_EN
        ,
        .trap_out             (trap_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_en_in     = 1'b0;
        mem_write_en_in    = 1'b0;
        mem_width_in       = 2'd0;
        mem_zero_extend_in = 1'b0;
        rd_in              = 5'd0;
        rd_writeback_in    = 1'b0;
        result_in          = 32'd0;
        rs2_value_in       = 32'd0;
        data_read_value_in = 32'd0;
        data_ready_in      = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_wb", 32'(rd_writeback_out), 32'd0);
        check("rst_value", rd_value_out, 32'd0);
        check("rst_strobes", {30'd0, data_read_out, data_write_out}, 32'd0);
        check("rst_buserr", 32'(bus_error_out), 32'd0);
        reset_n = 1'b1;

        // Non-memory instruction: one-cycle pass-through.
        rd_in = 5'd5; rd_writeback_in = 1'b1; result_in = 32'h1234;
        step();
        check("alu_rd", 32'(rd_out), 32'd5);
        check("alu_wb", 32'(rd_writeback_out), 32'd1);
        check("alu_value", rd_value_out, 32'h1234);
        check("alu_stall", 32'(stall_out), 32'd0);

        // Writes to x0 never write back.
        rd_in = 5'd0; result_in = 32'h55;
        step();
        check("x0_wb", 32'(rd_writeback_out), 32'd0);
        check("x0_value", rd_value_out, 32'h55);

        // Signed byte load from 0x103, ready on the third BUS cycle.
        mem_read_en_in = 1'b1; mem_width_in = 2'd0; mem_zero_extend_in = 1'b0;
        rd_in = 5'd7; rd_writeback_in = 1'b1; result_in = 32'h103;
        step();
        check("lb_read", 32'(data_read_out), 32'd1);
        check("lb_write", 32'(data_write_out), 32'd0);
        check("lb_addr", data_address_out, 32'h100);
        check("lb_stall", 32'(stall_out), 32'd1);
        check("lb_wb_pending", 32'(rd_writeback_out), 32'd0);
        step();
        step();
        check("lb_read_held", 32'(data_read_out), 32'd1);
        check("lb_stall_held", 32'(stall_out), 32'd1);
        data_ready_in = 1'b1; data_read_value_in = 32'h80FFFFFF;
        step();
        check("lb_read_done", 32'(data_read_out), 32'd0);
        check("lb_stall_done", 32'(stall_out), 32'd0);
        check("lb_value", rd_value_out, 32'hFFFFFF80);
        check("lb_wb", 32'(rd_writeback_out), 32'd1);
        check("lb_rd", 32'(rd_out), 32'd7);
        idle_inputs();

        // Zero-extended half load from 0x206, ready immediately (2-cycle latency).
        mem_read_en_in = 1'b1; mem_width_in = 2'd1; mem_zero_extend_in = 1'b1;
        rd_in = 5'd8; rd_writeback_in = 1'b1; result_in = 32'h206;
        step();
        check("lhu_addr", data_address_out, 32'h204);
        data_ready_in = 1'b1; data_read_value_in = 32'h80FFFFFF;
        step();
        check("lhu_value", rd_value_out, 32'h000080FF);
        check("lhu_wb", 32'(rd_writeback_out), 32'd1);
        idle_inputs();

        // Half store to 0x202 with read also asserted: store wins.
        mem_read_en_in = 1'b1; mem_write_en_in = 1'b1; mem_width_in = 2'd1;
        rd_in = 5'd9; rd_writeback_in = 1'b1; result_in = 32'h202; rs2_value_in = 32'hAAAABEEF;
        step();
        check("sh_write", 32'(data_write_out), 32'd1);
        check("sh_read", 32'(data_read_out), 32'd0);
        check("sh_addr", data_address_out, 32'h200);
        check("sh_mask", 32'(data_write_mask_out), 32'hC);
        check("sh_data", data_write_value_out, 32'hBEEFBEEF);
        step();
        check("sh_stall_held", 32'(stall_out), 32'd1);
        check("sh_write_held", 32'(data_write_out), 32'd1);
        data_ready_in = 1'b1;
        step();
        check("sh_write_done", 32'(data_write_out), 32'd0);
        check("sh_stall_done", 32'(stall_out), 32'd0);
        check("sh_wb", 32'(rd_writeback_out), 32'd0);
        idle_inputs();

        // Byte store to 0x301.
        mem_write_en_in = 1'b1; mem_width_in = 2'd0; result_in = 32'h301; rs2_value_in = 32'h12345678;
        step();
        check("sb_mask", 32'(data_write_mask_out), 32'h2);
        check("sb_data", data_write_value_out, 32'h78787878);
        data_ready_in = 1'b1;
        step();
        check("sb_done", 32'(data_write_out), 32'd0);
        idle_inputs();

        // Timeout: WAIT_LIMIT=4, ready never comes.
        mem_read_en_in = 1'b1; mem_width_in = 2'd2; rd_in = 5'd3; rd_writeback_in = 1'b1;
        result_in = 32'h400;
        step();
        step();
        step();
        step();
        check("to_read_4th", 32'(data_read_out), 32'd1);
        check("to_err_early", 32'(bus_error_out), 32'd0);
        step();
        check("to_read_low", 32'(data_read_out), 32'd0);
        check("to_err", 32'(bus_error_out), 32'd1);
        check("to_wb", 32'(rd_writeback_out), 32'd0);
        check("to_stall", 32'(stall_out), 32'd0);
        idle_inputs();
        step();
        check("to_err_pulse", 32'(bus_error_out), 32'd0);

        // Reset in the middle of a word store.
        mem_write_en_in = 1'b1; mem_width_in = 2'd2; rd_in = 5'd6; result_in = 32'h500;
        rs2_value_in = 32'hDEADBEEF;
        step();
        check("rb_write", 32'(data_write_out), 32'd1);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check("rb_write_drop", 32'(data_write_out), 32'd0);
        check("rb_stall_drop", 32'(stall_out), 32'd0);
        check("rb_mask_drop", 32'(data_write_mask_out), 32'd0);
        check("rb_rd_drop", 32'(rd_out), 32'd0);
        step();
        reset_n = 1'b1;
        rd_in = 5'd4; rd_writeback_in = 1'b1; result_in = 32'hCAFE;
        step();
        check("rb_alu_rd", 32'(rd_out), 32'd4);
        check("rb_alu_value", rd_value_out, 32'hCAFE);
        idle_inputs();
        mem_read_en_in = 1'b1; mem_width_in = 2'd2; rd_in = 5'd10; rd_writeback_in = 1'b1;
        result_in = 32'h600;
        step();
        data_ready_in = 1'b1; data_read_value_in = 32'h13579BDF;
        step();
        check("rb_lw_value", rd_value_out, 32'h13579BDF);
        check("rb_lw_wb", 32'(rd_writeback_out), 32'd1);
        idle_inputs();

        // Misaligned word load from 0x101.
        mem_read_en_in = 1'b1; mem_width_in = 2'd2; rd_in = 5'd11; rd_writeback_in = 1'b1;
        result_in = 32'h101;
        step();
`ifdef RV32_MISALIGN_TRAP_EN
        check("mis_read", 32'(data_read_out), 32'd0);
        check("mis_stall", 32'(stall_out), 32'd0);
        check("mis_trap", 32'(trap_out), 32'd1);
        check("mis_wb", 32'(rd_writeback_out), 32'd0);
        idle_inputs();
        step();
        check("mis_trap_pulse", 32'(trap_out), 32'd0);
`else
        check("mis_read", 32'(data_read_out), 32'd1);
        check("mis_addr", data_address_out, 32'h100);
        data_ready_in = 1'b1; data_read_value_in = 32'hA5A5F00D;
        step();
        check("mis_value", rd_value_out, 32'hA5A5F00D);
        check("mis_wb", 32'(rd_writeback_out), 32'd1);
        idle_inputs();
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
